spi_cont_byte_sequencer: RTL

- Host-side stage directly upstream of the SPI controller (master) byte engine.
- Buffers host bytes in a TX FIFO and launches them one at a time into the controller with single-cycle data-valid pulses when the controller is ready.
- Captures every received byte into an RX FIFO for the host.
- Guarantees exactly one byte in flight and no RX byte loss.

---
 rtl/spi_cont_seq_pkg.sv | 21 ++
 rtl/spi_cont_sync_fifo.sv | 71 +++++++
 rtl/spi_cont_byte_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/spi_cont_seq_pkg.sv
// spi_cont_seq_pkg
// Shared definitions for the SPI controller byte sequencer:
//   BYTE_W      - width of one SPI byte
//   seq_state_e - launch/capture FSM states
//   lvl_w()     - bit width of a FIFO occupancy count (0..depth inclusive)
package spi_cont_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_RX = 2'd2
  } seq_state_e;

  // A count that must reach depth itself needs one bit more than the address.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_cont_sync_fifo.sv
// spi_cont_sync_fifo
// Single-clock show-ahead FIFO used for both the TX and RX byte queues.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   push, push_data      - write request and data (ignored when full)
//   pop, pop_data        - read request (ignored when empty), head entry
//   full, empty, level   - status decoded from the registered occupancy
// A push while full is dropped even if a pop happens in the same cycle.
module spi_cont_sync_fifo
  import spi_cont_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Acceptance is judged on the occupancy before this cycle's edge.
  assign push_ok_s = push && (count_r != LW'(DEPTH));
  assign pop_ok_s  = pop  && (count_r != LW'(0));

  assign full     = (count_r == LW'(DEPTH));
  assign empty    = (count_r == LW'(0));
  assign level    = count_r;
  assign pop_data = mem_r[rd_ptr_r[AW-1:0]];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_cont_byte_sequencer.sv
// spi_cont_byte_sequencer
// Host-side stage in front of an SPI controller byte engine. Host bytes are
// queued in a TX FIFO and launched one at a time with a one-cycle o_TX_DV
// pulse; each received byte is captured into an RX FIFO for the host.
// Ports:
//   i_Clk, i_Rst_L                         - clock, async active-low reset
//   i_Host_Byte, i_Host_Wr, o_Host_Full,
//   o_Host_TX_Level                        - host TX queue interface
//   i_Host_Rd, o_Host_RX_Byte,
//   o_Host_RX_Empty                        - host RX queue (show-ahead)
//   o_Busy, o_Err_Ovf, o_Err_Unexp,
//   i_Clr_Err                              - status and sticky errors
//   o_TX_Byte, o_TX_DV, i_TX_Ready,
//   i_RX_DV, i_RX_Byte                     - SPI controller side
module spi_cont_byte_sequencer
  import spi_cont_seq_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst_L,
  input  logic [BYTE_W-1:0]              i_Host_Byte,
  input  logic                           i_Host_Wr,
  output logic                           o_Host_Full,
  output logic [lvl_w(TX_DEPTH)-1:0]     o_Host_TX_Level,
  input  logic                           i_Host_Rd,
  output logic [BYTE_W-1:0]              o_Host_RX_Byte,
  output logic                           o_Host_RX_Empty,
  output logic                           o_Busy,
  output logic                           o_Err_Ovf,
  output logic                           o_Err_Unexp,
  input  logic                           i_Clr_Err,
  output logic [BYTE_W-1:0]              o_TX_Byte,
  output logic                           o_TX_DV,
  input  logic                           i_TX_Ready,
  input  logic                           i_RX_DV,
  input  logic [BYTE_W-1:0]              i_RX_Byte
);

  seq_state_e                   state_r;
  logic [BYTE_W-1:0]            tx_byte_r;
  logic                         tx_dv_r;
  logic                         busy_r;
  logic                         err_ovf_r;
  logic                         err_unexp_r;

  logic [BYTE_W-1:0]            tx_head_s;
  logic                         tx_full_s;
  logic                         tx_empty_s;
  logic [lvl_w(TX_DEPTH)-1:0]   tx_level_s;
  logic [BYTE_W-1:0]            rx_head_s;
  logic                         rx_full_s;
  logic                         rx_empty_s;
  logic [lvl_w(RX_DEPTH)-1:0]   rx_level_s;
  logic                         rx_level_unused_s;
  logic                         tx_pop_s;
  logic                         rx_push_s;

  assign rx_level_unused_s = ^rx_level_s;

  spi_cont_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (i_Clk),
    .rst_n     (i_Rst_L),
    .push      (i_Host_Wr),
    .push_data (i_Host_Byte),
    .pop       (tx_pop_s),
    .pop_data  (tx_head_s),
    .full      (tx_full_s),
    .empty     (tx_empty_s),
    .level     (tx_level_s)
  );

  spi_cont_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (i_Clk),
    .rst_n     (i_Rst_L),
    .push      (rx_push_s),
    .push_data (i_RX_Byte),
    .pop       (i_Host_Rd),
    .pop_data  (rx_head_s),
    .full      (rx_full_s),
    .empty     (rx_empty_s),
    .level     (rx_level_s)
  );

  // Launch only with a free RX slot so the echo of this byte can never be lost.
  always_comb begin
    tx_pop_s  = 1'b0;
    rx_push_s = 1'b0;
    if (state_r == IDLE) begin
      tx_pop_s = !tx_empty_s && i_TX_Ready && !rx_full_s;
    end else if (state_r == WAIT_RX) begin
      rx_push_s = i_RX_DV;
    end else begin
      tx_pop_s  = 1'b0;
      rx_push_s = 1'b0;
    end
  end

  // Sequencer FSM, launch registers, busy flag and sticky errors.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r     <= IDLE;
      tx_byte_r   <= '0;
      tx_dv_r     <= 1'b0;
      busy_r      <= 1'b0;
      err_ovf_r   <= 1'b0;
      err_unexp_r <= 1'b0;
    end else begin
      busy_r      <= (state_r != IDLE) || !tx_empty_s;
      // Clear wins over a set in the same cycle.
      err_ovf_r   <= i_Clr_Err ? 1'b0 : (err_ovf_r | (i_Host_Wr & tx_full_s));
      err_unexp_r <= i_Clr_Err ? 1'b0 : (err_unexp_r | (i_RX_DV & (state_r != WAIT_RX)));
      case (state_r)
        IDLE: begin
          if (tx_pop_s) begin
            tx_byte_r <= tx_head_s;
            tx_dv_r   <= 1'b1;
            state_r   <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_dv_r <= 1'b0;
          state_r <= WAIT_RX;
        end
        WAIT_RX: begin
          if (i_RX_DV) begin
            state_r <= IDLE;
          end
        end
        default: begin
          tx_dv_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_Host_Full     = tx_full_s;
  assign o_Host_TX_Level = tx_level_s;
  assign o_Host_RX_Byte  = rx_head_s;
  assign o_Host_RX_Empty = rx_empty_s;
  assign o_Busy          = busy_r;
  assign o_Err_Ovf       = err_ovf_r;
  assign o_Err_Unexp     = err_unexp_r;
  assign o_TX_Byte       = tx_byte_r;
  assign o_TX_DV         = tx_dv_r;

endmodule
